// File: rtl/hex_display_tx.sv
// rtl/hex_display_tx.sv - formats a WIDTH-bit word as lowercase hex ASCII digits followed by a newline
// Output characters are registered and held until the sink accepts them.
module hex_display_tx #(
  parameter int WIDTH = 32,
  parameter int LZ    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_char,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int NDIG = WIDTH / 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIGIT   = 2'd1,
    NEWLINE = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       idx;
  logic [WIDTH-1:0] word;
  logic [63:0]      word_ext;
  logic [63:0]      data_ext;
  logic [3:0]       lead_idx;
  logic [3:0]       start_idx;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  function automatic logic [3:0] nibble(input logic [63:0] w, input logic [3:0] i);
    return w[{i, 2'b00} +: 4];
  endfunction

  // Zero-extend to 64 bits so the dynamic nibble select never runs off the end.
  always_comb begin
    word_ext = '0;
    word_ext[WIDTH-1:0] = word;
    data_ext = '0;
    data_ext[WIDTH-1:0] = in_data;
  end

  // Highest nonzero nibble wins; an all-zero word still prints one digit.
  always_comb begin
    lead_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (in_data[i*4 +: 4] != 4'h0) begin
        lead_idx = 4'(i);
      end
    end
  end

  assign start_idx = (LZ != 0) ? lead_idx : 4'(NDIG - 1);
  assign in_ready  = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      word      <= '0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word      <= in_data;
            idx       <= start_idx;
            state     <= DIGIT;
            out_valid <= 1'b1;
            out_char  <= hex_ascii(nibble(data_ext, start_idx));
            out_last  <= 1'b0;
          end
        end
        DIGIT: begin
          if (out_ready) begin
            if (idx != 4'd0) begin
              idx      <= idx - 4'd1;
              out_char <= hex_ascii(nibble(word_ext, idx - 4'd1));
            end else begin
              state    <= NEWLINE;
              out_char <= 8'h0a;
              out_last <= 1'b1;
            end
          end
        end
        NEWLINE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            out_last  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_char  <= 8'h00;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
